inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Fetch stage directly upstream of the instruction cache.
- Owns the PC and drives the cache's enable and address; the cache read is combinational and returns its hit flag in the same cycle.
- Captures each returned instruction, with its PC, into a small in-order queue that the issue stage drains.
- Handles PC redirects from branch resolution by flushing the queue and restarting fetch.

Parameters:
- ADDR_W, `Inst_Addr_Width: PC / cache address width.
- INST_W, `Inst_Width: instruction width.
- DEPTH, 4: queue entries; must be a power of two, at least 2.
- RESET_PC, 0: PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- icache_ce  out  1  cache enable.
- icache_addr  out  ADDR_W  fetch address (the PC).
- icache_inst  in  INST_W  instruction from the cache, already byte-ordered.
- icache_enable  in  1  cache returned valid data this cycle.
- deq_valid  out  1  queue head is valid.
- deq_inst  out  INST_W  head instruction.
- deq_pc  out  ADDR_W  head PC.
- deq_ready  in  1  issue stage accepts the head this cycle.
- redirect_valid  in  1  branch or jump redirect.
- redirect_pc  in  ADDR_W  new fetch PC.
- q_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - pc = RESET_PC; count = 0; rd_ptr = wr_ptr = 0.
  - deq_valid = 0; q_count = 0.
  - icache_ce = 0 while rst is high, forced combinationally.
- State: pc register, circular buffer of DEPTH x {pc, inst}, rd_ptr, wr_ptr, count.
- Fetch request (combinational):
  - icache_ce = !rst && !redirect_valid && (count < DEPTH).
  - icache_addr = pc at all times, with bits [1:0] = 0.
  - Fetch never depends combinationally on deq_ready.
- Push: on a clock edge where icache_ce && icache_enable:
  - write {pc, icache_inst} at wr_ptr;
  - wr_ptr++;
  - pc <= pc + 4, wrapping modulo 2^ADDR_W.
  - If icache_ce is high but icache_enable is low: no push, pc holds, and the request retries next cycle.
- Pop:
  - deq_valid = (count != 0) && !redirect_valid.
  - On an edge where deq_valid && deq_ready: rd_ptr++.
  - deq_inst and deq_pc come combinationally from entry rd_ptr. Their value is don't-care when deq_valid = 0, but they must never be X after reset.
- count update:
  - count += push - pop.
  - Push and pop in the same cycle leave count unchanged.
  - Push is impossible at count == DEPTH, so no overflow.
  - Pop is impossible at count == 0, so no underflow.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Latency: an instruction fetched in cycle N is visible at deq_* in cycle N+1. Sustained throughput is 1 instruction/cycle when deq_ready is held high.
- Redirect:
  - redirect_valid has priority over push and pop.
  - On its edge: count <= 0; rd_ptr <= wr_ptr <= 0; pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - The same-cycle fetch is suppressed (icache_ce = 0) and the same-cycle dequeue is suppressed (deq_valid = 0).
  - The first fetch from the new PC occurs in the following cycle.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: all state returns to reset values immediately, without waiting for an edge. Any in-flight entries are discarded.
- No state machine beyond the counter; the FETCH/FULL/FLUSH conditions are derived from count and redirect_valid.

Decomposition:
- Shared defines (existing `Inst_Addr_Width, `Inst_Width) stay in defines.v.
- Add `Pc_Step (4) and `Reset_Pc there.
- Natural sub-module: fetch_fifo, a generic DEPTH-entry synchronous FIFO with a flush input.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - inst_fetch_queue adds the PC register, the request logic and the redirect priority.

Test Plan:
- Reset release, icache_enable = 1, deq_ready = 1, cache holds instructions I0..I7 at word addresses 0..7 → icache_addr sequence 0, 4, 8, ...; deq_pc/deq_inst show 0/I0 in cycle 2, then 4/I1, and so on, one per cycle.
- deq_ready = 0 from reset → exactly 4 pushes (pc reaches 16); icache_ce drops to 0; q_count = 4. Then deq_ready = 1 for 1 cycle → pops PC 0, and the next cycle fetches 16.
- Queue holding 3 entries, redirect_valid = 1 with redirect_pc = 0x103 → deq_valid = 0 and icache_ce = 0 that cycle. Next cycle q_count = 0 and icache_addr = 0x100; following cycle deq_pc = 0x100.
- icache_enable = 0 for 3 cycles mid-stream at pc = 0x20 → pc holds at 0x20 and no entries are added. Then it resumes with 0x20, with no duplicated or missing PCs.
- pc = 2^ADDR_W - 4 → next fetch address is 0 (wrap); the queue pointers wrap after DEPTH pushes and pops while the order is preserved.
- Assert rst asynchronously between edges with q_count = 2 → icache_ce, deq_valid and q_count go to 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared widths and constants for the fetch queue
// Purpose: default widths and fetch constants imported by the fetch queue files.
// Ports: none.
package inst_fetch_queue_pkg;

  localparam int INST_ADDR_WIDTH  = 32;  // default PC / cache address width
  localparam int INST_WIDTH       = 32;  // default instruction width
  localparam int PC_STEP          = 4;   // bytes per sequential fetch
  localparam int RESET_PC_DEFAULT = 0;   // PC loaded on reset

  // Number of bits needed to hold an occupancy in 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// rtl/inst_fetch_queue_fifo.sv - generic synchronous FIFO with flush
// Purpose: DEPTH-entry in-order buffer; flush empties it and rewinds the pointers.
// Ports: clk/rst (async, active-high), push/pop/flush controls, din/dout data,
//        count occupancy, full/empty status. dout reads entry rd_ptr combinationally.
module inst_fetch_queue_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [W-1:0]                  din,
  output logic [W-1:0]                  dout,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so increments wrap for free.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is reset too so dout is never X, even before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push && !flush) mem_q[wr_ptr_q] <= din;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch stage: PC, icache request and in-order fetch queue
// Purpose: owns the PC, requests instructions from a combinational icache, queues
//          {pc, inst} for the issue stage and restarts fetch on redirects.
// Ports: clk/rst (async, active-high); icache_ce/icache_addr request,
//        icache_inst/icache_enable response; deq_valid/deq_inst/deq_pc/deq_ready
//        issue handshake; redirect_valid/redirect_pc flush; q_count occupancy.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int              ADDR_W   = INST_ADDR_WIDTH,
  parameter int              INST_W   = INST_WIDTH,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          icache_ce,
  output logic [ADDR_W-1:0]             icache_addr,
  input  logic [INST_W-1:0]             icache_inst,
  input  logic                          icache_enable,
  output logic                          deq_valid,
  output logic [INST_W-1:0]             deq_inst,
  output logic [ADDR_W-1:0]             deq_pc,
  input  logic                          deq_ready,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic [count_width(DEPTH)-1:0] q_count
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic                     push, pop;
  logic                     full, empty;
  logic [ADDR_W+INST_W-1:0] fifo_dout;

  // Redirect outranks everything: it blocks this cycle's fetch and dequeue.
  assign icache_ce   = !rst && !redirect_valid && !full;
  assign icache_addr = pc_q & ALIGN_MASK;
  assign push        = icache_ce && icache_enable;
  assign deq_valid   = !empty && !redirect_valid;
  assign pop         = deq_valid && deq_ready;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc & ALIGN_MASK;
    else if (push)      pc_d = icache_addr + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC & ALIGN_MASK;
    else     pc_q <= pc_d;
  end

  inst_fetch_queue_fifo #(
    .W     (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({icache_addr, icache_inst}),
    .dout  (fifo_dout),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

  assign deq_pc   = fifo_dout[ADDR_W+INST_W-1:INST_W];
  assign deq_inst = fifo_dout[INST_W-1:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  localparam int ADDR_W = 16;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              icache_ce;
  logic [ADDR_W-1:0] icache_addr;
  logic [INST_W-1:0] icache_inst;
  logic              icache_enable;
  logic              deq_valid;
  logic [INST_W-1:0] deq_inst;
  logic [ADDR_W-1:0] deq_pc;
  logic              deq_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [2:0]        q_count;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] m_pc;
  int          m_count;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] a);
    return {~a, a};
  endfunction

  // Cache memory image: each word address holds a distinct instruction.
  assign icache_inst = inst_of(icache_addr);

  inst_fetch_queue #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_ce      (icache_ce),
    .icache_addr    (icache_addr),
    .icache_inst    (icache_inst),
    .icache_enable  (icache_enable),
    .deq_valid      (deq_valid),
    .deq_inst       (deq_inst),
    .deq_pc         (deq_pc),
    .deq_ready      (deq_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .q_count        (q_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, update the model, advance past the rising edge.
  task automatic step();
    logic exp_ce, exp_dv, do_push, do_pop;
    ent_t e;
    @(negedge clk);
    exp_ce = !redirect_valid && (m_count < DEPTH);
    exp_dv = (m_count != 0) && !redirect_valid;
    chk("icache_ce", 64'(icache_ce), 64'(exp_ce));
    chk("icache_addr", 64'(icache_addr), 64'(m_pc));
    chk("deq_valid", 64'(deq_valid), 64'(exp_dv));
    chk("q_count", 64'(q_count), 64'(m_count));
    do_push = exp_ce && icache_enable;
    do_pop  = exp_dv && deq_ready;
    if (do_pop) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 64'(0), 64'(1));
      end else begin
        e = sb.pop_front();
        chk("deq_pc", 64'(deq_pc), 64'(e.pc));
        chk("deq_inst", 64'(deq_inst), 64'(e.inst));
      end
    end
    if (do_push) begin
      e.pc   = m_pc;
      e.inst = inst_of(m_pc);
      sb.push_back(e);
    end
    if (redirect_valid) begin
      m_pc    = redirect_pc & 16'hFFFC;
      m_count = 0;
      sb.delete();
    end else begin
      if (do_push) m_pc = m_pc + 16'd4;
      m_count = m_count + int'(do_push) - int'(do_pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    icache_enable  = 1'b0;
    deq_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    m_pc           = 16'h0;
    m_count        = 0;

    repeat (2) @(posedge clk);
    #2;
    chk("reset_ce", 64'(icache_ce), 64'(0));
    chk("reset_dv", 64'(deq_valid), 64'(0));
    chk("reset_count", 64'(q_count), 64'(0));
    chk("reset_addr", 64'(icache_addr), 64'(0));

    // Streaming from reset: one instruction per cycle, order preserved.
    @(posedge clk);
    #1;
    rst           = 1'b0;
    icache_enable = 1'b1;
    deq_ready     = 1'b1;
    repeat (10) step();

    // Fill from PC 0 with the issue stage stalled.
    deq_ready = 1'b0;
    do_redirect(16'h0000);
    repeat (6) step();
    chk("full_count", 64'(q_count), 64'(4));
    chk("full_addr", 64'(icache_addr), 64'(16));
    chk("full_ce", 64'(icache_ce), 64'(0));
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    step();
    chk("refill_count", 64'(q_count), 64'(4));
    deq_ready     = 1'b1;
    icache_enable = 1'b0;
    step();
    chk("three_count", 64'(q_count), 64'(3));

    // Redirect to an unaligned target flushes the queue.
    icache_enable = 1'b1;
    do_redirect(16'h0103);
    chk("redir_count", 64'(q_count), 64'(0));
    chk("redir_addr", 64'(icache_addr), 64'(16'h0100));
    repeat (4) step();

    // Cache misses at 0x20 stall fetch without losing or duplicating PCs.
    do_redirect(16'h0010);
    repeat (4) step();
    icache_enable = 1'b0;
    repeat (3) step();
    chk("miss_addr", 64'(icache_addr), 64'(16'h0020));
    icache_enable = 1'b1;
    repeat (4) step();

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    step();
    do_redirect(16'hFFF8);
    chk("wrap_start", 64'(icache_addr), 64'(16'hFFF8));

    // PC wraps through zero; then random back-pressure exercises pointer wrap.
    repeat (6) step();
    for (int i = 0; i < 24; i++) begin
      deq_ready     = 1'($urandom_range(0, 1));
      icache_enable = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset between edges with two entries queued.
    icache_enable = 1'b1;
    deq_ready     = 1'b0;
    do_redirect(16'h0040);
    repeat (2) step();
    chk("pre_reset_count", 64'(q_count), 64'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("async_ce", 64'(icache_ce), 64'(0));
    chk("async_dv", 64'(deq_valid), 64'(0));
    chk("async_count", 64'(q_count), 64'(0));
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_pc    = 16'h0;
    m_count = 0;
    sb.delete();
    deq_ready = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
